perm_block_sequencer: RTL and testbench

- Sequences one 200-byte block (25 x 64-bit words) through the permutation core, sitting between the NoC interface buffers and the perm core.
- On a start pulse it streams 25 words from the input buffer into the perm (pushin/firstin, honouring stopin), then opens the output side (stopout low) and collects 25 result words into the output buffer.
- Reports done, or reports an error with a code on a framing violation or an output timeout.

---
 rtl/perm_block_sequencer.sv | 135 +++++++++++++
 tb/tb_perm_block_sequencer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/perm_block_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : perm_block_sequencer
// Purpose  : Feeds one NWORDS-word block from the input buffer into the perm
//            core, then collects the result block into the output buffer.
// Revision : 1.0
// ============================================================================
module perm_block_sequencer #(
   parameter int NWORDS  = 25,
   parameter int WIDTH   = 64,
   parameter int AW      = 5,
   parameter int TIMEOUT = 1023
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [1:0]       err_code,
   output logic [AW-1:0]    src_rd_addr,
   input  logic [WIDTH-1:0] src_rd_data,
   output logic             dst_wr_en,
   output logic [AW-1:0]    dst_wr_addr,
   output logic [WIDTH-1:0] dst_wr_data,
   output logic             pushin,
   output logic             firstin,
   output logic [WIDTH-1:0] din,
   input  logic             stopin,
   input  logic             pushout,
   input  logic             firstout,
   input  logic [WIDTH-1:0] dout,
   output logic             stopout
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_FEED    = 3'd1,
      S_COLLECT = 3'd2,
      S_DONE    = 3'd3,
      S_ERR     = 3'd4
   } state_t;

   localparam logic [AW-1:0] c_LAST_IDX  = AW'(NWORDS - 1);
   localparam logic [9:0]    c_TMO_MAX   = 10'(TIMEOUT);
   localparam logic [1:0]    c_ERR_FRAME = 2'd1;
   localparam logic [1:0]    c_ERR_TMO   = 2'd2;

   state_t          r_state;
   logic [AW-1:0]   r_idx;
   logic [9:0]      r_tmo;
   logic [1:0]      r_err_code;

   logic            w_feed;
   logic            w_collect;
   logic            w_idx_zero;
   logic            w_frame_bad;
   logic            w_push;

   assign w_feed      = (r_state == S_FEED);
   assign w_collect   = (r_state == S_COLLECT);
   assign w_idx_zero  = (r_idx == '0);
   // Word 0 must carry firstout, every later word must not.
   assign w_frame_bad = (w_idx_zero && !firstout) || (!w_idx_zero && firstout);
   assign w_push      = w_feed && !stopin;

   assign src_rd_addr = r_idx;
   assign din         = src_rd_data;
   assign pushin      = w_push;
   assign firstin     = w_push && w_idx_zero;

   assign stopout     = !w_collect;
   assign dst_wr_en   = w_collect && pushout && !w_frame_bad;
   assign dst_wr_addr = r_idx;
   assign dst_wr_data = dout;

   assign busy        = (r_state != S_IDLE);
   assign done        = (r_state == S_DONE);
   assign err         = (r_state == S_ERR);
   assign err_code    = r_err_code;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_idx      <= '0;
         r_tmo      <= '0;
         r_err_code <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_state    <= S_FEED;
                  r_idx      <= '0;
                  r_err_code <= '0;
               end
            end
            S_FEED: begin
               if (!stopin) begin
                  if (r_idx == c_LAST_IDX) begin
                     r_state <= S_COLLECT;
                     r_idx   <= '0;
                     r_tmo   <= '0;
                  end else begin
                     r_idx <= r_idx + 1'b1;
                  end
               end
            end
            S_COLLECT: begin
               if (pushout) begin
                  r_tmo <= '0;
                  if (w_frame_bad) begin
                     r_err_code <= c_ERR_FRAME;
                     r_state    <= S_ERR;
                  end else if (r_idx == c_LAST_IDX) begin
                     r_state <= S_DONE;
                  end else begin
                     r_idx <= r_idx + 1'b1;
                  end
               end else if (r_tmo == c_TMO_MAX) begin
                  r_err_code <= c_ERR_TMO;
                  r_state    <= S_ERR;
               end else begin
                  r_tmo <= r_tmo + 10'd1;
               end
            end
            S_DONE:  r_state <= S_IDLE;
            S_ERR:   r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_perm_block_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_perm_block_sequencer
// Purpose  : Transaction-level checks of perm_block_sequencer against a
//            buffer/perm model built from word lists and delay queues.
// Revision : 1.0
// ============================================================================
module tb_perm_block_sequencer;

   localparam int NWORDS  = 25;
   localparam int WIDTH   = 64;
   localparam int AW      = 5;
   localparam int TIMEOUT = 1023;

   logic             clk = 1'b0;
   logic             rst, start, busy, done, err;
   logic [1:0]       err_code;
   logic [AW-1:0]    src_rd_addr, dst_wr_addr;
   logic [WIDTH-1:0] src_rd_data, dst_wr_data, din, dout;
   logic             dst_wr_en, pushin, firstin, stopin, pushout, firstout, stopout;

   logic [WIDTH-1:0] mem [0:31];
   assign src_rd_data = mem[src_rd_addr];

   always #5 clk = ~clk;

   perm_block_sequencer #(
      .NWORDS(NWORDS), .WIDTH(WIDTH), .AW(AW), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .err(err),
      .err_code(err_code), .src_rd_addr(src_rd_addr), .src_rd_data(src_rd_data),
      .dst_wr_en(dst_wr_en), .dst_wr_addr(dst_wr_addr), .dst_wr_data(dst_wr_data),
      .pushin(pushin), .firstin(firstin), .din(din), .stopin(stopin),
      .pushout(pushout), .firstout(firstout), .dout(dout), .stopout(stopout)
   );

   int nerr = 0, nchk = 0, cyc = 0, rel = 0;
   bit obs = 0, active = 0;
   int perm_delay = 3, bad_idx = -1, perm_silent = 0, gap_pct = 0, stall_pct = 0;
   int stall_lo = -1, stall_hi = -1, xs0 = -1, xs1 = -1;
   int fed, outn, wrn, n_done, n_err, t_collect, t_done, t_err, t_last_push, rel_done;
   logic [WIDTH-1:0] pq_d [$];
   int               pq_t [$];
   logic       s_busy, s_stopout, s_pushin, s_done, s_err;
   logic [1:0] s_err_code, code_end;
   logic       stop_end;

   // Stand-in for the perm core: a fixed bijection applied per word.
   function automatic logic [WIDTH-1:0] pf(input logic [WIDTH-1:0] x);
      return {x[40:0], x[63:41]} ^ 64'h5A5A_F00F_1234_8421;
   endfunction

   task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      nchk++;
      assert (observed === expected)
      else begin
         nerr++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic observe();
      if (active && fed < NWORDS) chk("pushin_vs_stopin", pushin, !stopin);
      else                        chk("pushin_quiet", pushin, 0);
      if (pushin) begin
         if (fed < NWORDS) begin
            chk("din", din, mem[fed]);
            chk("firstin", firstin, fed == 0);
         end
         pq_d.push_back(din);
         pq_t.push_back(cyc + perm_delay);
         fed++;
      end else begin
         chk("firstin_quiet", firstin, 0);
         if (active && fed < NWORDS) chk("din_hold", din, mem[fed]);
      end
      if (pushout) begin
         if (outn == bad_idx) chk("frame_err_no_write", dst_wr_en, 0);
         else begin
            chk("wr_en", dst_wr_en, 1);
            chk("wr_addr", dst_wr_addr, outn);
            chk("wr_data", dst_wr_data, pf(mem[outn]));
         end
         void'(pq_d.pop_front());
         void'(pq_t.pop_front());
         outn++;
         t_last_push = cyc;
      end else begin
         chk("wr_quiet", dst_wr_en, 0);
      end
      if (dst_wr_en === 1'b1) wrn++;
      if (stopout === 1'b0 && t_collect < 0) t_collect = cyc;
      if (done === 1'b1) begin n_done++; t_done = cyc; rel_done = rel; end
      if (err === 1'b1) begin n_err++; t_err = cyc; end
   endtask

   // One clock cycle: drive inputs, let them settle, sample, then advance.
   task automatic tick(input logic st);
      start    = st || (rel == xs0) || (rel == xs1);
      stopin   = (rel >= stall_lo && rel <= stall_hi) || (int'($urandom_range(99)) < stall_pct);
      pushout  = 1'b0;
      firstout = 1'b0;
      dout     = {$urandom, $urandom};
      #1;
      if (perm_silent == 0 && stopout === 1'b0 && pq_d.size() > 0 && pq_t[0] <= cyc
          && int'($urandom_range(99)) >= gap_pct) begin
         pushout  = 1'b1;
         firstout = (outn == 0) != (outn == bad_idx);
         dout     = pf(pq_d[0]);
      end
      #1;
      s_busy = busy; s_stopout = stopout; s_pushin = pushin;
      s_done = done; s_err = err; s_err_code = err_code;
      if (obs) observe();
      @(posedge clk);
      #1;
      cyc++;
      rel++;
   endtask

   task automatic clear_block();
      fed = 0; outn = 0; wrn = 0; n_done = 0; n_err = 0;
      t_collect = -1; t_done = -1; t_err = -1; t_last_push = -1; rel_done = -1;
      pq_d.delete(); pq_t.delete();
      rel = 0; active = 0;
   endtask

   // kind: 0 = expect done, 1 = expect framing error, 2 = expect timeout
   task automatic run_block(input int kind, input int exp_done_rel);
      clear_block();
      tick(1);
      active = 1;
      tick(0);
      chk("busy_in_feed", s_busy, 1);
      chk("err_code_cleared", s_err_code, 0);
      for (int i = 0; i < 3000 && n_done == 0 && n_err == 0; i++) tick(0);
      chk("block_finished", (n_done + n_err) != 0, 1);
      code_end = s_err_code;
      stop_end = s_stopout;
      tick(0);
      chk("busy_after_end", s_busy, 0);
      chk("stopout_after_end", s_stopout, 1);
      tick(0);
      chk("fed_count", fed, NWORDS);
      if (kind == 0) begin
         chk("done_count", n_done, 1);
         chk("err_count", n_err, 0);
         chk("write_count", wrn, NWORDS);
         chk("done_latency", t_done - t_last_push, 1);
         if (exp_done_rel >= 0) chk("done_cycle", rel_done, exp_done_rel);
      end else if (kind == 1) begin
         chk("err_count", n_err, 1);
         chk("done_count", n_done, 0);
         chk("err_code_frame", code_end, 1);
         chk("err_code_hold", s_err_code, 1);
         chk("writes_before_err", wrn, bad_idx);
      end else begin
         chk("err_count", n_err, 1);
         chk("done_count", n_done, 0);
         chk("err_code_tmo", code_end, 2);
         chk("tmo_latency", t_err - t_collect, TIMEOUT + 1);
         chk("stopout_at_err", stop_end, 1);
         chk("writes_tmo", wrn, 0);
      end
      active = 0; xs0 = -1; xs1 = -1;
   endtask

   task automatic load_basic();
      for (int i = 0; i < 32; i++) mem[i] = 64'h0101_0101_0101_0101 * 64'(i);
   endtask

   task automatic load_random();
      for (int i = 0; i < 32; i++) mem[i] = {$urandom, $urandom};
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; stopin = 1'b0; pushout = 1'b0; firstout = 1'b0; dout = '0;
      load_basic();
      clear_block();

      // Reset values
      tick(0);
      tick(0);
      chk("rst_busy", s_busy, 0);
      chk("rst_stopout", s_stopout, 1);
      chk("rst_pushin", s_pushin, 0);
      chk("rst_done", s_done, 0);
      chk("rst_err", s_err, 0);
      chk("rst_err_code", s_err_code, 0);
      rst = 1'b0;
      obs = 1;
      tick(0);

      // Basic block, perm echo after 3 cycles
      run_block(0, 51);

      // Start pulses during FEED and during the DONE cycle are ignored
      xs0 = 7; xs1 = 51;
      run_block(0, 51);

      // Back-pressure on FEED cycles 5..9
      stall_lo = 5; stall_hi = 9;
      run_block(0, 56);
      stall_lo = -1; stall_hi = -1;

      // Framing error on result word 3
      load_random();
      bad_idx = 3;
      run_block(1, -1);
      bad_idx = -1;

      // Perm never answers
      perm_silent = 1;
      run_block(2, -1);
      perm_silent = 0;

      // Reset in the middle of FEED at idx 12
      load_basic();
      clear_block();
      tick(1);
      active = 1;
      for (int i = 0; i < 200 && fed < 12; i++) tick(0);
      chk("reached_idx12", fed, 12);
      rst = 1'b1;
      tick(0);
      rst = 1'b0;
      active = 0;
      pq_d.delete(); pq_t.delete();
      tick(0);
      chk("midrst_pushin", s_pushin, 0);
      chk("midrst_stopout", s_stopout, 1);
      chk("midrst_busy", s_busy, 0);
      chk("midrst_err_code", s_err_code, 0);
      chk("midrst_no_done", n_done + n_err, 0);
      run_block(0, 51);

      // Randomized data, stalls and perm output gaps
      for (int b = 0; b < 3; b++) begin
         load_random();
         stall_pct  = 25;
         gap_pct    = 30;
         perm_delay = int'($urandom_range(6, 1));
         run_block(0, -1);
      end
      stall_pct = 0; gap_pct = 0; perm_delay = 3;

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
`default_nettype wire
